alu_issue_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_rr_arbiter.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds the opcode map, the error data word and the controller FSM state encoding.
package alu_pkg;

  localparam logic [3:0] OPC_ARITH  = 4'b0000;
  localparam logic [3:0] OPC_LOGIC  = 4'b0001;
  localparam logic [3:0] OPC_SHIFT  = 4'b0010;
  localparam logic [3:0] OPC_ROT    = 4'b0011;
  localparam logic [3:0] OPC_CMP    = 4'b0100;
  localparam logic [3:0] OPC_MINMAX = 4'b0101;
  localparam logic [3:0] OPC_BITCNT = 4'b0110;
  localparam logic [3:0] OPC_BREV   = 4'b0111;
  localparam logic [3:0] OPC_BYTE   = 4'b1000;
  localparam logic [3:0] OPC_EXT    = 4'b1001;
  localparam logic [3:0] OPC_CRC    = 4'b1010;

  // Returned in place of a result for illegal opcodes and watchdog expiry.
  localparam logic [31:0] ALU_ERR_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after (ptr + 1) mod NREQ.
//   req     : request vector
//   ptr     : index of the most recently served requester
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
module alu_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PtrW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PtrW-1:0] gnt_idx
);

  logic [PtrW-1:0] idx;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    // Walk NREQ positions starting just after the last winner.
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = PtrW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one ALU between NREQ requesters.
// Round-robin picks a requester in IDLE, its operands are latched, the ALU gets a
// one-cycle strobe, the result (or an error) is returned on a valid/ready channel.
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : per-requester request handshake (ready one-hot)
//   req_opcode/funct/a/b       : packed request payloads, slice i = requester i
//   rsp_valid/rsp_ready        : per-requester response handshake (valid one-hot)
//   rsp_data/rsp_ovf/rsp_err   : shared response payload
//   alu_valid_i, alu_opcode..b : issue side of the ALU
//   alu_o, alu_valid_o, alu_overflow : ALU result side
//   busy                       : controller not idle
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [3:0]  MAX_OPC = 4'b1010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_opcode,
  input  logic [3*NREQ-1:0] req_funct,
  input  logic [32*NREQ-1:0] req_a,
  input  logic [32*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              alu_valid_i,
  output logic [3:0]        alu_opcode,
  output logic [2:0]        alu_funct,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_o,
  input  logic              alu_valid_o,
  input  logic              alu_overflow,
  output logic              busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(TIMEOUT);

  alu_state_e      state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] gidx_q, gidx_d;
  logic [3:0]      opc_q, opc_d;
  logic [2:0]      funct_q, funct_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [PtrW-1:0] gnt_idx;

  logic [3:0]  opc_arr   [NREQ];
  logic [2:0]  funct_arr [NREQ];
  logic [31:0] a_arr     [NREQ];
  logic [31:0] b_arr     [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign opc_arr[i]   = req_opcode[4*i +: 4];
    assign funct_arr[i] = req_funct[3*i +: 3];
    assign a_arr[i]     = req_a[32*i +: 32];
    assign b_arr[i]     = req_b[32*i +: 32];
  end

  alu_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    opc_d     = opc_q;
    funct_d   = funct_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_ready = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = gnt;
        if (|req_valid) begin
          gidx_d  = gnt_idx;
          opc_d   = opc_arr[gnt_idx];
          funct_d = funct_arr[gnt_idx];
          a_d     = a_arr[gnt_idx];
          b_d     = b_arr[gnt_idx];
          if (opc_arr[gnt_idx] > MAX_OPC) begin
            // Reject without touching the ALU.
            data_d  = ALU_ERR_DATA;
            ovf_d   = 1'b0;
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (alu_valid_o) begin
          data_d  = alu_o;
          ovf_d   = (opc_q == OPC_ARITH) & alu_overflow;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // A result arriving on the last watchdog cycle still wins.
        if (alu_valid_o) begin
          data_d  = alu_o;
          ovf_d   = (opc_q == OPC_ARITH) & alu_overflow;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          data_d  = ALU_ERR_DATA;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready[gidx_q]) begin
          ptr_d   = gidx_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == StResp) begin
      rsp_valid[gidx_q] = 1'b1;
    end
  end

  // Operands are only presented to the ALU while an op is in flight.
  assign alu_valid_i = (state_q == StIssue);
  assign alu_opcode  = (state_q == StIdle) ? 4'd0  : opc_q;
  assign alu_funct   = (state_q == StIdle) ? 3'd0  : funct_q;
  assign alu_a       = (state_q == StIdle) ? 32'd0 : a_q;
  assign alu_b       = (state_q == StIdle) ? 32'd0 : b_q;
  assign rsp_data    = data_q;
  assign rsp_ovf     = ovf_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= PtrW'(NREQ - 1);
      gidx_q  <= '0;
      opc_q   <= '0;
      funct_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      opc_q   <= opc_d;
      funct_q <= funct_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a latency-programmable ALU stub.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned N    = 3;
  localparam int unsigned TO   = 8;
  localparam logic [3:0]  MAXO = 4'b1010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [4*N-1:0]  req_opcode = '0;
  logic [3*N-1:0]  req_funct = '0;
  logic [32*N-1:0] req_a = '0;
  logic [32*N-1:0] req_b = '0;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready = '0;
  logic [31:0]     rsp_data;
  logic            rsp_ovf, rsp_err;
  logic            alu_valid_i;
  logic [3:0]      alu_opcode;
  logic [2:0]      alu_funct;
  logic [31:0]     alu_a, alu_b;
  logic [31:0]     alu_o = '0;
  logic            alu_valid_o = 1'b0;
  logic            alu_overflow = 1'b0;
  logic            busy;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .NREQ    (N),
    .TIMEOUT (TO),
    .MAX_OPC (MAXO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_funct    (req_funct),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_ovf      (rsp_ovf),
    .rsp_err      (rsp_err),
    .alu_valid_i  (alu_valid_i),
    .alu_opcode   (alu_opcode),
    .alu_funct    (alu_funct),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_o        (alu_o),
    .alu_valid_o  (alu_valid_o),
    .alu_overflow (alu_overflow),
    .busy         (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stub ALU behaviour: add with signed overflow for arithmetic, a mixing function
  // otherwise; non-arithmetic ops always raise overflow so masking is visible.
  function automatic logic [31:0] f_res(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    if (op == OPC_ARITH) return a + b;
    return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
  endfunction

  function automatic logic f_ovf(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    if (op == OPC_ARITH) return (a[31] == b[31]) && (s[31] != a[31]);
    return 1'b1;
  endfunction

  // ALU stub: answers stub_lat cycles after the strobe (0 = same cycle).
  int          stub_lat = 0;
  bit          stub_on = 1'b1;
  int          stub_cnt = 0;
  bit          stub_armed = 1'b0;
  logic [3:0]  s_op = '0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;

  always @(negedge clk) begin
    if (alu_valid_i) begin
      stub_armed = 1'b1;
      stub_cnt   = 0;
      s_op = alu_opcode;
      s_a  = alu_a;
      s_b  = alu_b;
    end else if (stub_armed) begin
      stub_cnt++;
    end
    if (stub_armed && stub_on && stub_cnt == stub_lat) begin
      alu_valid_o  = 1'b1;
      alu_o        = f_res(s_op, s_a, s_b);
      alu_overflow = f_ovf(s_op, s_a, s_b);
      stub_armed   = 1'b0;
    end else begin
      alu_valid_o  = 1'b0;
      alu_o        = $urandom;
      alu_overflow = 1'($urandom_range(0, 1));
    end
  end

  // Per-requester payloads and reference round-robin pointer.
  logic [3:0]  t_op [N];
  logic [2:0]  t_fn [N];
  logic [31:0] t_a  [N];
  logic [31:0] t_b  [N];
  int          m_ptr = N - 1;

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      t_op[i] = 4'($urandom_range(0, 15));
      t_fn[i] = 3'($urandom);
      t_a[i]  = $urandom;
      t_b[i]  = $urandom;
    end
  endtask

  // One complete transaction: request in IDLE, track to response, hold for
  // 'hold' cycles of backpressure, then complete the handshake.
  task automatic run_txn(input logic [N-1:0] mask, input int lat, input bit on,
                         input int hold, output logic [N-1:0] obs_gnt);
    int g, j, cyc, pulses, exp_lat, exp_pulses;
    logic [N-1:0] oh;
    logic [31:0] d_exp;
    logic o_exp, e_exp;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_opcode[4*i +: 4] = t_op[i];
      req_funct[3*i +: 3]  = t_fn[i];
      req_a[32*i +: 32]    = t_a[i];
      req_b[32*i +: 32]    = t_b[i];
    end
    req_valid = mask;
    rsp_ready = '0;
    stub_lat  = lat;
    stub_on   = on;
    #1;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      j = (m_ptr + k) % N;
      if (g < 0 && mask[j]) g = j;
    end
    oh = '0;
    oh[g] = 1'b1;
    obs_gnt = req_ready;
    chk("idle_busy", busy, 0);
    chk("req_ready", req_ready, oh);
    chk("idle_alu", {alu_valid_i, alu_opcode, alu_funct, alu_a, alu_b}, 0);
    if (t_op[g] > MAXO) begin
      exp_lat = 1; exp_pulses = 0; d_exp = 32'hDEADBEEF; o_exp = 0; e_exp = 1;
    end else if (on && lat <= TO) begin
      exp_lat = 2 + lat; exp_pulses = 1;
      d_exp = f_res(t_op[g], t_a[g], t_b[g]);
      o_exp = (t_op[g] == 4'd0) ? f_ovf(t_op[g], t_a[g], t_b[g]) : 1'b0;
      e_exp = 0;
    end else begin
      exp_lat = TO + 2; exp_pulses = 1; d_exp = 32'hDEADBEEF; o_exp = 0; e_exp = 1;
    end
    cyc = 1;
    pulses = 0;
    @(negedge clk);
    req_valid = N'($urandom);
    #1;
    while (rsp_valid == '0 && cyc < int'(TO) + 8) begin
      chk("busy", busy, 1);
      chk("ready_low", req_ready, 0);
      chk("alu_ops", {alu_opcode, alu_funct, alu_a, alu_b}, {t_op[g], t_fn[g], t_a[g], t_b[g]});
      if (alu_valid_i) pulses++;
      @(negedge clk);
      req_valid = N'($urandom);
      cyc++;
      #1;
    end
    chk("rsp_latency", cyc, exp_lat);
    chk("alu_pulses", pulses, exp_pulses);
    for (int h = 0; h <= hold; h++) begin
      if (h < hold) rsp_ready = ~oh;
      else rsp_ready = oh | N'($urandom);
      chk("rsp_valid", rsp_valid, oh);
      chk("rsp_payload", {rsp_data, rsp_ovf, rsp_err}, {d_exp, o_exp, e_exp});
      chk("rsp_busy", busy, 1);
      chk("rsp_alu_ops", {alu_opcode, alu_funct, alu_a, alu_b},
          {t_op[g], t_fn[g], t_a[g], t_b[g]});
      if (h < hold) begin
        @(negedge clk);
        #1;
        req_valid = N'($urandom);
      end
    end
    req_valid = '0;
    m_ptr = g;
  endtask

  logic [N-1:0] og;

  initial begin
    // Reset state.
    #3;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err, alu_valid_i,
                          alu_opcode, alu_funct, alu_a, alu_b, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic overflow, combinational ALU.
    fill_random();
    t_op[0] = OPC_ARITH; t_a[0] = 32'h7FFFFFFF; t_b[0] = 32'd1;
    run_txn(3'b001, 0, 1'b1, 0, og);
    chk("ovf_grant", og, 3'b001);

    // Fairness: requesters 0 and 1 held back to back.
    for (int i = 0; i < 4; i++) begin
      fill_random();
      t_op[0] = OPC_LOGIC; t_op[1] = OPC_CMP;
      run_txn(3'b011, 0, 1'b1, 0, og);
      chk("fair_seq", og, (i % 2 == 0) ? 3'b010 : 3'b001);
    end

    // Illegal opcode from requester 1.
    fill_random();
    t_op[1] = 4'b1100;
    run_txn(3'b010, 0, 1'b1, 0, og);

    // Multi-cycle shift with backpressure.
    fill_random();
    t_op[2] = OPC_SHIFT;
    run_txn(3'b100, 5, 1'b1, 3, og);

    // Watchdog expiry, then a result on the final watchdog cycle.
    fill_random();
    t_op[0] = OPC_SHIFT;
    run_txn(3'b001, TO + 1, 1'b0, 1, og);
    fill_random();
    t_op[1] = OPC_ROT;
    run_txn(3'b010, TO, 1'b1, 0, og);

    // Reset while waiting on the ALU.
    fill_random();
    t_op[2] = OPC_SHIFT;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_opcode[4*i +: 4] = t_op[i];
      req_funct[3*i +: 3]  = t_fn[i];
      req_a[32*i +: 32]    = t_a[i];
      req_b[32*i +: 32]    = t_b[i];
    end
    req_valid = 3'b100;
    stub_lat = 6;
    stub_on = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outputs", {req_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err, alu_valid_i,
                        alu_opcode, alu_funct, alu_a, alu_b, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = N - 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("stale_rsp", {rsp_valid, busy}, 0);
    end
    fill_random();
    t_op[0] = OPC_LOGIC;
    run_txn(3'b111, 1, 1'b1, 0, og);
    chk("post_rst_grant", og, 3'b001);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      int lat;
      fill_random();
      lat = $urandom_range(0, TO + 2);
      run_txn(N'($urandom_range(1, (1 << N) - 1)), lat, (lat <= int'(TO)), $urandom_range(0, 3),
              og);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
